// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Shares the register file's single synchronous write port between two
//   writeback requesters. A (main pipeline) has fixed priority; B (long-latency
//   unit) is protected from starvation by a saturating loss counter. The
//   accepted write is registered into an output stage driving the rf port.
//
// Ports
//   i_clk, i_rst_n                      clock, async active-low reset
//   i_a_valid/o_a_ready/i_a_waddr/i_a_wdata   requester A handshake + payload
//   i_b_valid/o_b_ready/i_b_waddr/i_b_wdata   requester B handshake + payload
//   o_rd_wen/o_rd_waddr/o_rd_wdata       registered rf write port
//   o_pending                            one-hot of register being written
//   o_b_boost                            starvation counter at STARVE_LIMIT
module rf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_a_valid,
  output logic        o_a_ready,
  input  logic [4:0]  i_a_waddr,
  input  logic [31:0] i_a_wdata,
  input  logic        i_b_valid,
  output logic        o_b_ready,
  input  logic [4:0]  i_b_waddr,
  input  logic [31:0] i_b_wdata,
  output logic        o_rd_wen,
  output logic [4:0]  o_rd_waddr,
  output logic [31:0] o_rd_wdata,
  output logic [31:0] o_pending,
  output logic        o_b_boost
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       boost;
  logic       grant_a;
  logic       grant_b;

  // The output stage never stalls, so a grant is always a transfer.
  always_comb begin
    boost     = (starve_cnt == LIMIT);
    grant_b   = i_b_valid && (!i_a_valid || boost);
    grant_a   = i_a_valid && !grant_b;
    o_a_ready = grant_a && i_rst_n;
    o_b_ready = grant_b && i_rst_n;
    o_b_boost = boost;
  end

  // Counts consecutive cycles B is valid but loses to A.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_cnt <= '0;
    end else if (!i_b_valid || grant_b) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // x0 writes are consumed and loaded, but never enable the rf write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_wen   <= 1'b0;
      o_rd_waddr <= '0;
      o_rd_wdata <= '0;
    end else if (grant_a) begin
      o_rd_wen   <= (i_a_waddr != 5'd0);
      o_rd_waddr <= i_a_waddr;
      o_rd_wdata <= i_a_wdata;
    end else if (grant_b) begin
      o_rd_wen   <= (i_b_waddr != 5'd0);
      o_rd_waddr <= i_b_waddr;
      o_rd_wdata <= i_b_wdata;
    end else begin
      o_rd_wen   <= 1'b0;
    end
  end

  always_comb begin
    o_pending = o_rd_wen ? (32'd1 << o_rd_waddr) : '0;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic        b_valid;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;

  logic        u4_a_ready, u4_b_ready, u4_wen, u4_boost;
  logic [4:0]  u4_waddr;
  logic [31:0] u4_wdata, u4_pending;
  logic        u1_a_ready, u1_b_ready, u1_wen, u1_boost;
  logic [4:0]  u1_waddr;
  logic [31:0] u1_wdata, u1_pending;

  int n_cmp = 0;
  int n_err = 0;

  rf_wb_arbiter #(.STARVE_LIMIT(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_valid(a_valid), .o_a_ready(u4_a_ready), .i_a_waddr(a_waddr), .i_a_wdata(a_wdata),
    .i_b_valid(b_valid), .o_b_ready(u4_b_ready), .i_b_waddr(b_waddr), .i_b_wdata(b_wdata),
    .o_rd_wen(u4_wen), .o_rd_waddr(u4_waddr), .o_rd_wdata(u4_wdata),
    .o_pending(u4_pending), .o_b_boost(u4_boost)
  );

  rf_wb_arbiter #(.STARVE_LIMIT(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_valid(a_valid), .o_a_ready(u1_a_ready), .i_a_waddr(a_waddr), .i_a_wdata(a_wdata),
    .i_b_valid(b_valid), .o_b_ready(u1_b_ready), .i_b_waddr(b_waddr), .i_b_wdata(b_wdata),
    .o_rd_wen(u1_wen), .o_rd_waddr(u1_waddr), .o_rd_wdata(u1_wdata),
    .o_pending(u1_pending), .o_b_boost(u1_boost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 1'b1; a_waddr = 5'd3; a_wdata = 32'h1;
    b_valid = 1'b1; b_waddr = 5'd4; b_wdata = 32'h2;
    @(negedge clk);
    #1;
    n_cmp++; if (u4_a_ready !== 1'b0) begin n_err++; $display("FAIL rst_a_ready got %b exp 0", u4_a_ready); end
    n_cmp++; if (u4_b_ready !== 1'b0) begin n_err++; $display("FAIL rst_b_ready got %b exp 0", u4_b_ready); end
    n_cmp++; if (u4_wen !== 1'b0) begin n_err++; $display("FAIL rst_wen got %b exp 0", u4_wen); end
    n_cmp++; if (u4_pending !== 32'h0) begin n_err++; $display("FAIL rst_pending got %h exp 0", u4_pending); end
    n_cmp++; if (u4_boost !== 1'b0) begin n_err++; $display("FAIL rst_boost got %b exp 0", u4_boost); end
    n_cmp++; if (u4_waddr !== 5'd0 || u4_wdata !== 32'h0) begin n_err++; $display("FAIL rst_addr_data got %h/%h exp 0/0", u4_waddr, u4_wdata); end
    n_cmp++; if (u1_a_ready !== 1'b0 || u1_b_ready !== 1'b0) begin n_err++; $display("FAIL rst1_ready got %b%b exp 00", u1_a_ready, u1_b_ready); end
    n_cmp++; if (u1_wen !== 1'b0 || u1_pending !== 32'h0 || u1_boost !== 1'b0 || u1_wdata !== 32'h0)
      begin n_err++; $display("FAIL rst1_out got wen=%b pend=%h boost=%b data=%h exp 0", u1_wen, u1_pending, u1_boost, u1_wdata); end
  endtask

  task automatic test_a_alone();
    do_reset();
    a_valid = 1'b1; a_waddr = 5'd5; a_wdata = 32'hDEADBEEF; b_valid = 1'b0;
    #1;
    n_cmp++; if (u4_a_ready !== 1'b1) begin n_err++; $display("FAIL a_alone_ready got %b exp 1", u4_a_ready); end
    n_cmp++; if (u4_b_ready !== 1'b0) begin n_err++; $display("FAIL a_alone_b_ready got %b exp 0", u4_b_ready); end
    @(negedge clk);
    n_cmp++; if (u4_wen !== 1'b1) begin n_err++; $display("FAIL a_alone_wen got %b exp 1", u4_wen); end
    n_cmp++; if (u4_waddr !== 5'd5) begin n_err++; $display("FAIL a_alone_waddr got %0d exp 5", u4_waddr); end
    n_cmp++; if (u4_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL a_alone_wdata got %h exp deadbeef", u4_wdata); end
    n_cmp++; if (u4_pending !== 32'h00000020) begin n_err++; $display("FAIL a_alone_pending got %h exp 00000020", u4_pending); end
    a_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (u4_wen !== 1'b0) begin n_err++; $display("FAIL a_alone_idle_wen got %b exp 0", u4_wen); end
    n_cmp++; if (u4_pending !== 32'h0) begin n_err++; $display("FAIL a_alone_idle_pending got %h exp 0", u4_pending); end
    n_cmp++; if (u4_waddr !== 5'd5 || u4_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL a_alone_hold got %0d/%h exp 5/deadbeef", u4_waddr, u4_wdata); end
  endtask

  task automatic test_contention();
    logic exp_b4, exp_b1, prev_b4, prev_b1;
    do_reset();
    a_valid = 1'b1; a_waddr = 5'd1; a_wdata = 32'hAAAA0001;
    b_valid = 1'b1; b_waddr = 5'd2; b_wdata = 32'hBBBB0002;
    prev_b4 = 1'b0; prev_b1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        @(negedge clk);
        n_cmp++; if (u4_wen !== 1'b1 || u4_waddr !== (prev_b4 ? 5'd2 : 5'd1))
          begin n_err++; $display("FAIL cont4_out[%0d] got wen=%b addr=%0d exp 1/%0d", k, u4_wen, u4_waddr, prev_b4 ? 2 : 1); end
        n_cmp++; if (u1_wen !== 1'b1 || u1_waddr !== (prev_b1 ? 5'd2 : 5'd1))
          begin n_err++; $display("FAIL cont1_out[%0d] got wen=%b addr=%0d exp 1/%0d", k, u1_wen, u1_waddr, prev_b1 ? 2 : 1); end
      end
      #1;
      exp_b4 = ((k % 5) == 4);
      exp_b1 = ((k % 2) == 1);
      n_cmp++; if (u4_b_ready !== exp_b4 || u4_a_ready !== !exp_b4)
        begin n_err++; $display("FAIL cont4_grant[%0d] got a=%b b=%b exp b=%b", k, u4_a_ready, u4_b_ready, exp_b4); end
      n_cmp++; if (u4_boost !== exp_b4) begin n_err++; $display("FAIL cont4_boost[%0d] got %b exp %b", k, u4_boost, exp_b4); end
      n_cmp++; if (u1_b_ready !== exp_b1 || u1_a_ready !== !exp_b1)
        begin n_err++; $display("FAIL cont1_grant[%0d] got a=%b b=%b exp b=%b", k, u1_a_ready, u1_b_ready, exp_b1); end
      n_cmp++; if (u1_boost !== exp_b1) begin n_err++; $display("FAIL cont1_boost[%0d] got %b exp %b", k, u1_boost, exp_b1); end
      prev_b4 = exp_b4; prev_b1 = exp_b1;
    end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_x0_drop();
    do_reset();
    b_valid = 1'b1; b_waddr = 5'd0; b_wdata = 32'h12345678; a_valid = 1'b0;
    #1;
    n_cmp++; if (u4_b_ready !== 1'b1) begin n_err++; $display("FAIL x0_b_ready got %b exp 1", u4_b_ready); end
    @(negedge clk);
    b_valid = 1'b0;
    n_cmp++; if (u4_wen !== 1'b0) begin n_err++; $display("FAIL x0_wen got %b exp 0", u4_wen); end
    n_cmp++; if (u4_pending !== 32'h0) begin n_err++; $display("FAIL x0_pending got %h exp 0", u4_pending); end
    n_cmp++; if (u4_wdata !== 32'h12345678 || u4_waddr !== 5'd0) begin n_err++; $display("FAIL x0_loaded got %0d/%h exp 0/12345678", u4_waddr, u4_wdata); end
  endtask

  task automatic test_counter_clear();
    do_reset();
    a_valid = 1'b1; a_waddr = 5'd6; a_wdata = 32'h6;
    b_valid = 1'b1; b_waddr = 5'd8; b_wdata = 32'h8;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      n_cmp++; if (u4_a_ready !== 1'b1 || u4_b_ready !== 1'b0)
        begin n_err++; $display("FAIL clr_lose[%0d] got a=%b b=%b exp a=1 b=0", k, u4_a_ready, u4_b_ready); end
    end
    @(negedge clk);
    b_valid = 1'b0;
    #1;
    n_cmp++; if (u4_a_ready !== 1'b1 || u4_boost !== 1'b0)
      begin n_err++; $display("FAIL clr_gap got a=%b boost=%b exp 1/0", u4_a_ready, u4_boost); end
    @(negedge clk);
    b_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      n_cmp++; if (u4_b_ready !== (k == 4) || u4_a_ready !== (k != 4))
        begin n_err++; $display("FAIL clr_restart[%0d] got a=%b b=%b exp b=%b", k, u4_a_ready, u4_b_ready, k == 4); end
    end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    b_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(negedge clk);
        n_cmp++; if (u4_wen !== 1'b1 || u4_waddr !== 5'(9 + k) || u4_wdata !== 32'(k * 32'h1000))
          begin n_err++; $display("FAIL b2b_out[%0d] got wen=%b addr=%0d data=%h exp 1/%0d/%h", k, u4_wen, u4_waddr, u4_wdata, 9 + k, k * 32'h1000); end
      end
      if (k < 3) begin
        a_valid = 1'b1; a_waddr = 5'(10 + k); a_wdata = 32'((k + 1) * 32'h1000);
      end else begin
        a_valid = 1'b0;
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    a_valid = 1'b1; a_waddr = 5'd7; a_wdata = 32'h77; b_valid = 1'b0;
    @(negedge clk);
    a_valid = 1'b0;
    n_cmp++; if (u4_wen !== 1'b1 || u4_pending !== 32'h00000080)
      begin n_err++; $display("FAIL ar_pre got wen=%b pend=%h exp 1/00000080", u4_wen, u4_pending); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (u4_wen !== 1'b0) begin n_err++; $display("FAIL ar_wen got %b exp 0", u4_wen); end
    n_cmp++; if (u4_pending !== 32'h0) begin n_err++; $display("FAIL ar_pending got %h exp 0", u4_pending); end
    n_cmp++; if (u4_waddr !== 5'd0 || u4_wdata !== 32'h0) begin n_err++; $display("FAIL ar_clear got %0d/%h exp 0/0", u4_waddr, u4_wdata); end
    @(negedge clk);
    rst_n = 1'b1;
    a_valid = 1'b1; a_waddr = 5'd9; a_wdata = 32'h99;
    #1;
    n_cmp++; if (u4_a_ready !== 1'b1) begin n_err++; $display("FAIL ar_release_ready got %b exp 1", u4_a_ready); end
    @(negedge clk);
    a_valid = 1'b0;
    n_cmp++; if (u4_wen !== 1'b1 || u4_waddr !== 5'd9 || u4_wdata !== 32'h99 || u4_pending !== 32'h00000200)
      begin n_err++; $display("FAIL ar_first got wen=%b addr=%0d data=%h pend=%h exp 1/9/99/00000200", u4_wen, u4_waddr, u4_wdata, u4_pending); end
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_waddr = '0; a_wdata = '0;
    b_valid = 1'b0; b_waddr = '0; b_wdata = '0;
    test_reset();
    test_a_alone();
    test_contention();
    test_x0_drop();
    test_counter_clear();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter for the register file's single synchronous write port. It shares the port between two writeback requesters: A is the main pipeline writeback and B is a long-latency unit such as a divider or a load return. Each request is accepted with a valid/ready handshake and placed in a registered output stage that drives the rf write port. Fixed priority favours A, and a starvation counter guarantees B progress.

## Interface
- STARVE_LIMIT, default 4: number of consecutive cycles B may lose arbitration before it wins. Legal range 1..15; the counter is 4 bits.
- i_clk  in  1  global clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_a_valid  in  1  requester A has a write pending.
- o_a_ready  out  1  A's write is accepted this cycle.
- i_a_waddr  in  5  A destination register.
- i_a_wdata  in  32  A write data.
- i_b_valid  in  1  requester B has a write pending.
- o_b_ready  out  1  B's write is accepted this cycle.
- i_b_waddr  in  5  B destination register.
- i_b_wdata  in  32  B write data.
- o_rd_wen  out  1  rf write enable (registered).
- o_rd_waddr  out  5  rf write address (registered).
- o_rd_wdata  out  32  rf write data (registered).
- o_pending  out  32  one-hot mask of the register being written by the output stage this cycle; 0 when o_rd_wen=0.
- o_b_boost  out  1  starvation counter has reached STARVE_LIMIT.

## Operation
- Handshake:
  - A transfer occurs on a rising edge when valid && ready.
  - A requester holds valid, waddr and wdata stable until the transfer.
  - valid must not depend on ready. ready may depend combinationally on both valids and on the counter.
- Grant, combinational, at most one per cycle:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant B if starve_cnt == STARVE_LIMIT, else grant A.
  - Neither valid: no grant.
- While i_rst_n=0, o_a_ready and o_b_ready are forced to 0.
- starve_cnt, updated each edge:
  - Cleared if B is granted or i_b_valid=0.
  - Otherwise incremented, saturating at STARVE_LIMIT.
  - o_b_boost = (starve_cnt == STARVE_LIMIT).
- Output stage, on each edge:
  - Transfer occurs: load waddr/wdata from the granted requester. o_rd_wen = (waddr != 0).
  - x0 writes are consumed (ready asserted) but produce o_rd_wen=0. Address and data are still loaded.
  - No transfer: o_rd_wen=0; o_rd_waddr and o_rd_wdata hold their previous values.
- o_pending = o_rd_wen ? (1 << o_rd_waddr) : 0. This is combinational from the output registers.
- The output stage never stalls because the rf write port always completes in one cycle. Every granted request is therefore accepted with no backpressure beyond arbitration.

## Timing
- Reset, asynchronous:
  - o_rd_wen, o_rd_waddr, o_rd_wdata, o_pending, o_b_boost and starve_cnt go to 0 immediately, with no clock edge required.
  - A write held in the output stage at reset assertion is discarded.
- Release: the first handshake can complete on the first rising edge after i_rst_n goes high.
- Latency:
  - Handshake at edge N puts the write on the rf write port during cycle N..N+1.
  - The rf commits it at edge N+1.
  - Reads see the new value after edge N+1, or during cycle N..N+1 when rf bypass is enabled.
- Throughput: one write per cycle, sustained.
- Worst-case B wait while A is continuously valid: STARVE_LIMIT cycles. B is granted on cycle STARVE_LIMIT+1.
- Same destination address from both requesters: no merging. Writes occur in grant order, and the last one wins in the rf.

## Test plan
- Reset: hold i_rst_n=0 with both valids high → both readies 0, o_rd_wen=0, o_pending=0, o_b_boost=0.
- A alone: A valid, waddr=5, wdata=0xDEADBEEF → o_a_ready=1 in the same cycle. Next cycle: o_rd_wen=1, o_rd_waddr=5, o_rd_wdata=0xDEADBEEF, o_pending=0x00000020. The cycle after: o_rd_wen=0.
- Contention, STARVE_LIMIT=4, both valid every cycle:
  - Grant sequence is A,A,A,A,B repeating.
  - o_b_boost=1 only in the cycle B wins; the counter clears afterward.
  - Repeat with STARVE_LIMIT=1 → A,B alternate.
- x0 drop: B valid, waddr=0, wdata=0x12345678 → o_b_ready=1. Next cycle: o_rd_wen=0, o_pending=0.
- Counter clear: B valid and losing for 3 cycles, then B deasserts for 1 cycle, then both valid → starve_cnt restarts at 0, so A wins 4 more cycles before B.
- Async reset mid-stream: o_rd_wen=1 with waddr=7 → drop i_rst_n between clock edges → o_rd_wen=0 and o_pending=0 immediately. After release, the first handshake completes normally.
